// File: rtl/btn_conditioner.sv
// Four-channel push-button conditioner: 2-flop sync, per-channel debounce, press/release pulses.
// Optional long-press detector is compiled in with `define BTN_LONG_PRESS_EN.
module btn_chan #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d, prs_q, prs_d, rel_q, rel_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    prs_d = 1'b0;
    rel_d = 1'b0;
    if (sync2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      lvl_d = sync2_q;
      cnt_d = '0;
      prs_d = sync2_q;
      rel_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      prs_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      prs_q   <= prs_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = lvl_q;
  assign press_o   = prs_q;
  assign release_o = rel_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Saturating at LONG_CYCLES guarantees a single pulse per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!lvl_q) begin
      hold_d = '0;
    end else if (hold_q != HW'(LONG_CYCLES)) begin
      hold_d = hold_q + HW'(1);
      long_d = (hold_q == HW'(LONG_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif
endmodule

module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || LONG_CYCLES < 1) begin : g_bad_param
    $error("btn_conditioner: illegal DEBOUNCE_CYCLES or LONG_CYCLES");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (btn_in[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i])
    );
  end
endmodule
